// File: rtl/mini_calculator_top.sv
// Board top for a 4-bit calculator: synchronized button edges select add/sub/mul/div on the switch
// operands, and the signed result is scanned onto a 4-digit 7-segment display. Macro DEBOUNCE_EN.
module mini_calculator_top #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_i,
  input  logic [7:0] sw_i,
  output logic [6:0] seg_o,
  output logic [3:0] an_o,
  output logic       led_o
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] SegDash  = 7'b0111111;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = SegBlank;
    endcase
    return g;
  endfunction

  // Button synchronizer chain
  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] level;
  logic [3:0] prev_q;
  logic [3:0] btn_edge;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= 4'd0;
    end else begin
      sync_q[0] <= btn_i;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

`ifdef DEBOUNCE_EN
  localparam int unsigned DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES);

  logic [3:0]     deb_q;
  logic [DbW-1:0] db_cnt_q [4];

  // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (!rst) begin
      deb_q <= 4'd0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync_q[SYNC_STAGES-1][i] != deb_q[i]) begin
          if (db_cnt_q[i] == DbW'(DEBOUNCE_CYCLES - 1)) begin
            deb_q[i]    <= sync_q[SYNC_STAGES-1][i];
            db_cnt_q[i] <= '0;
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end

  assign level = deb_q;
`else
  assign level = sync_q[SYNC_STAGES-1];
`endif

  assign btn_edge = level & ~prev_q;

  // Arithmetic
  logic [3:0] op_a, op_b;
  logic [8:0] mag_q, mag_d;
  logic       neg_q, neg_d;
  logic       led_q, led_d;

  assign op_a = sw_i[7:4];
  assign op_b = sw_i[3:0];

  always_comb begin
    mag_d = mag_q;
    neg_d = neg_q;
    led_d = led_q;
    if (btn_edge[0]) begin
      mag_d = {5'd0, op_a} + {5'd0, op_b};
      neg_d = 1'b0;
      led_d = 1'b0;
    end else if (btn_edge[1]) begin
      if (op_a < op_b) begin
        mag_d = {5'd0, op_b - op_a};
        neg_d = 1'b1;
      end else begin
        mag_d = {5'd0, op_a - op_b};
        neg_d = 1'b0;
      end
      led_d = 1'b0;
    end else if (btn_edge[2]) begin
      mag_d = {5'd0, op_a} * {5'd0, op_b};
      neg_d = 1'b0;
      led_d = 1'b0;
    end else if (btn_edge[3]) begin
      neg_d = 1'b0;
      if (op_b == 4'd0) begin
        mag_d = 9'd0;
        led_d = 1'b1;
      end else begin
        mag_d = {5'd0, op_a / op_b};
        led_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_q <= 4'd0;
      mag_q  <= 9'd0;
      neg_q  <= 1'b0;
      led_q  <= 1'b0;
    end else begin
      prev_q <= level;
      mag_q  <= mag_d;
      neg_q  <= neg_d;
      led_q  <= led_d;
    end
  end

  assign led_o = led_q;

  // Double-dabble binary to BCD
  logic [11:0] bcd;

  always_comb begin
    bcd = 12'd0;
    for (int i = 8; i >= 0; i--) begin
      if (bcd[3:0] >= 4'd5)  bcd[3:0]  = bcd[3:0] + 4'd3;
      if (bcd[7:4] >= 4'd5)  bcd[7:4]  = bcd[7:4] + 4'd3;
      if (bcd[11:8] >= 4'd5) bcd[11:8] = bcd[11:8] + 4'd3;
      bcd = {bcd[10:0], mag_q[i]};
    end
  end

  // Display scan
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      an_q, an_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CntW'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
    an_d = ~(4'b0001 << idx_d);
    case (idx_d)
      2'd0:    seg_d = glyph(bcd[3:0]);
      2'd1:    seg_d = (bcd[11:4] == 8'd0) ? SegBlank : glyph(bcd[7:4]);
      2'd2:    seg_d = (bcd[11:8] == 4'd0) ? SegBlank : glyph(bcd[11:8]);
      default: seg_d = neg_q ? SegDash : SegBlank;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
      an_q  <= 4'b1110;
      seg_q <= 7'b1000000;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign seg_o = seg_q;
  assign an_o  = an_q;

endmodule

// File: tb/tb_mini_calculator_top.sv
// Directed bench for mini_calculator_top: expected display/LED states are queued at each press and
// compared after a full display scan.
module tb_mini_calculator_top;

  localparam int unsigned RefreshDiv = 2;
  localparam int unsigned SyncStages = 2;

  logic       clk;
  logic       rst;
  logic [3:0] btn_i;
  logic [7:0] sw_i;
  logic [6:0] seg_o;
  logic [3:0] an_o;
  logic       led_o;

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [6:0] d3;
    logic [6:0] d2;
    logic [6:0] d1;
    logic [6:0] d0;
    logic       led;
  } exp_t;

  exp_t sb[$];

  mini_calculator_top #(
    .REFRESH_DIV(RefreshDiv),
    .SYNC_STAGES(SyncStages)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .btn_i(btn_i),
    .sw_i (sw_i),
    .seg_o(seg_o),
    .an_o (an_o),
    .led_o(led_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] gl(input int d);
    logic [6:0] t [10];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return t[d];
  endfunction

  // op: 0 add, 1 sub, 2 mul, 3 div
  function automatic exp_t model(input int a, input int b, input int op);
    exp_t e;
    int m, h, t, u;
    bit n, l;
    n = 0;
    l = 0;
    case (op)
      0: m = a + b;
      1: begin m = (a >= b) ? a - b : b - a; n = (a < b); end
      2: m = a * b;
      default: begin
        if (b == 0) begin m = 0; l = 1; end
        else m = a / b;
      end
    endcase
    h = m / 100;
    t = (m / 10) % 10;
    u = m % 10;
    e.d0  = gl(u);
    e.d1  = (h == 0 && t == 0) ? 7'h7F : gl(t);
    e.d2  = (h == 0) ? 7'h7F : gl(h);
    e.d3  = n ? 7'h3F : 7'h7F;
    e.led = l;
    return e;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Watch one-and-a-bit scans, then compare each digit and the LED with the oldest expectation.
  task automatic check_display(input string tag);
    exp_t e;
    logic [6:0] seen_seg [4];
    logic [3:0] seen;
    int bad_an;
    seen   = 4'd0;
    bad_an = 0;
    for (int i = 0; i < 4; i++) seen_seg[i] = 7'h00;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 8'd1, 8'd0);
      return;
    end
    e = sb.pop_front();
    repeat (4) @(negedge clk);
    for (int c = 0; c < int'(6 * RefreshDiv); c++) begin
      @(negedge clk);
      case (an_o)
        4'b1110: begin seen_seg[0] = seg_o; seen[0] = 1'b1; end
        4'b1101: begin seen_seg[1] = seg_o; seen[1] = 1'b1; end
        4'b1011: begin seen_seg[2] = seg_o; seen[2] = 1'b1; end
        4'b0111: begin seen_seg[3] = seg_o; seen[3] = 1'b1; end
        default: bad_an++;
      endcase
    end
    check({tag, "_an_valid"}, 8'(bad_an), 8'd0);
    check({tag, "_seen"}, {4'd0, seen}, 8'h0F);
    check({tag, "_d0"}, {1'b0, seen_seg[0]}, {1'b0, e.d0});
    check({tag, "_d1"}, {1'b0, seen_seg[1]}, {1'b0, e.d1});
    check({tag, "_d2"}, {1'b0, seen_seg[2]}, {1'b0, e.d2});
    check({tag, "_d3"}, {1'b0, seen_seg[3]}, {1'b0, e.d3});
    check({tag, "_led"}, {7'd0, led_o}, {7'd0, e.led});
  endtask

  task automatic pulse(input logic [3:0] b, input logic [7:0] s, input int cycles);
    @(negedge clk);
    sw_i  = s;
    btn_i = b;
    repeat (cycles) @(negedge clk);
    btn_i = 4'd0;
    repeat (SyncStages + 3) @(negedge clk);
  endtask

  initial begin
    rst   = 1'b0;
    btn_i = 4'd0;
    sw_i  = 8'd0;
    @(negedge clk);
    check("rst_an", {4'd0, an_o}, 8'h0E);
    check("rst_seg", {1'b0, seg_o}, 8'h40);
    check("rst_led", {7'd0, led_o}, 8'd0);
    rst = 1'b1;
    sb.push_back(model(0, 0, 0));
    check_display("rst_scan");

    // Held subtract 2-2; switching operands mid-hold must not trigger another update.
    @(negedge clk);
    sw_i  = 8'h22;
    btn_i = 4'b0010;
    repeat (3) @(negedge clk);
    sw_i = 8'h51;
    repeat (6) @(negedge clk);
    btn_i = 4'd0;
    sb.push_back(model(2, 2, 1));
    check_display("sub_hold");

    pulse(4'b0010, 8'h3A, 1);
    sb.push_back(model(3, 10, 1));
    check_display("sub_neg");

    pulse(4'b0100, 8'hFF, 1);
    sb.push_back(model(15, 15, 2));
    check_display("mul_max");

    pulse(4'b0001, 8'hF4, 1);
    sb.push_back(model(15, 4, 0));
    check_display("add");

    pulse(4'b1000, 8'h90, 1);
    sb.push_back(model(9, 0, 3));
    check_display("div_zero");

    pulse(4'b1000, 8'h94, 1);
    sb.push_back(model(9, 4, 3));
    check_display("div");

    pulse(4'b0101, 8'h53, 1);
    sb.push_back(model(5, 3, 0));
    check_display("priority");

    // Reset while a press is still in the synchronizer; the edge must be lost.
    @(negedge clk);
    sw_i  = 8'h11;
    btn_i = 4'b0100;
    @(negedge clk);
    rst   = 1'b0;
    btn_i = 4'd0;
    @(negedge clk);
    check("rst2_an", {4'd0, an_o}, 8'h0E);
    check("rst2_seg", {1'b0, seg_o}, 8'h40);
    check("rst2_led", {7'd0, led_o}, 8'd0);
    rst = 1'b1;
    repeat (SyncStages + 3) @(negedge clk);
    sb.push_back(model(0, 0, 0));
    check_display("rst_mid");

    check("sb_drained", 8'(sb.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
